sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/audio_pkg.sv | 29 ++
 rtl/arb2_rr.sv | 39 +++
 rtl/sram_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types for the audio SRAM path: bus widths, address/sample types,
// arbiter state encoding and requester identity.
package audio_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 16;

    typedef logic [SRAM_AW-1:0] sram_addr_t;
    typedef logic [SRAM_DW-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        TURN = 2'd3
    } arb_state_t;

    // Identity of the requester that was granted most recently
    typedef enum logic {
        REQ_REC = 1'b0,
        REQ_PLY = 1'b1
    } req_id_t;

    // True while the SRAM is actually being driven (RD or WR)
    function automatic logic is_access(input arb_state_t st);
        return (st == RD) || (st == WR);
    endfunction

endpackage

// File: rtl/arb2_rr.sv
// Two-input round-robin grant. Grant is combinational; the pointer of the
// last served requester is registered and only moves when a grant is issued.
module arb2_rr
    import audio_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_rec,
    input  logic req_ply,
    input  logic grant_en,
    output logic gnt_rec,
    output logic gnt_ply
);

    req_id_t last_r;

    // Grant: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        gnt_rec = 1'b0;
        gnt_ply = 1'b0;
        if (grant_en) begin
            if (req_rec && req_ply) begin
                if (last_r == REQ_PLY) gnt_rec = 1'b1;
                else                   gnt_ply = 1'b1;
            end else begin
                gnt_rec = req_rec;
                gnt_ply = req_ply;
            end
        end
    end

    // Pointer: reset to player so the recorder wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          last_r <= REQ_PLY;
        else if (gnt_rec) last_r <= REQ_REC;
        else if (gnt_ply) last_r <= REQ_PLY;
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates a recorder (writes) and a player (reads) onto one async SRAM.
// Each access lasts ACCESS_CYC cycles, followed by one bus-turnaround cycle
// on which the completion pulse (rec_ack / ply_valid) is presented.
// The bidirectional DQ pad (sram_dq_oe ? sram_dq_o : 'z) lives outside.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | bus released; arbitrate and latch the winner's request
//   RD    | SRAM read, oe_n low; last cycle captures sram_dq_i
//   WR    | SRAM write, we_n low, DQ driven with the latched sample
//   TURN  | one-cycle bus turnaround; ack/valid pulse is high here
module sram_arbiter
    import audio_pkg::*;
#(
    parameter int ACCESS_CYC = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rec_req,
    input  logic [SRAM_AW-1:0]  rec_addr,
    input  logic [SRAM_DW-1:0]  rec_wdata,
    output logic                rec_ack,
    input  logic                ply_req,
    input  logic [SRAM_AW-1:0]  ply_addr,
    output logic [SRAM_DW-1:0]  ply_rdata,
    output logic                ply_valid,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [SRAM_DW-1:0]  sram_dq_o,
    output logic                sram_dq_oe,
    input  logic [SRAM_DW-1:0]  sram_dq_i,
    output logic                sram_we_n,
    output logic                sram_ce_n,
    output logic                sram_oe_n,
    output logic                sram_ub_n,
    output logic                sram_lb_n,
    output logic                busy
);

    localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYC - 1);

    arb_state_t  state_r, state_nx;
    logic [3:0]  cnt_r, cnt_nx;
    sram_addr_t  addr_r;
    sample_t     wdata_r;
    sample_t     rdata_r;
    logic        rec_ack_r;
    logic        ply_valid_r;
    logic        grant_en;
    logic        gnt_rec;
    logic        gnt_ply;
    logic        last_cyc;

    arb2_rr u_arb (
        .clk      (clk),
        .rst      (rst),
        .req_rec  (rec_req),
        .req_ply  (ply_req),
        .grant_en (grant_en),
        .gnt_rec  (gnt_rec),
        .gnt_ply  (gnt_ply)
    );

    assign last_cyc = (cnt_r == CNT_LAST);

    // Next state, access counter and SRAM control decode
    always_comb begin
        state_nx   = state_r;
        cnt_nx     = cnt_r;
        grant_en   = 1'b0;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_lb_n  = 1'b1;
        sram_dq_oe = 1'b0;
        case (state_r)
            IDLE: begin
                grant_en = 1'b1;
                cnt_nx   = 4'd0;
                if (gnt_rec)      state_nx = WR;
                else if (gnt_ply) state_nx = RD;
            end
            RD: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
                if (last_cyc) state_nx = TURN;
                else          cnt_nx   = cnt_r + 4'd1;
            end
            WR: begin
                sram_ce_n  = 1'b0;
                sram_we_n  = 1'b0;
                sram_ub_n  = 1'b0;
                sram_lb_n  = 1'b0;
                sram_dq_oe = 1'b1;
                if (last_cyc) state_nx = TURN;
                else          cnt_nx   = cnt_r + 4'd1;
            end
            TURN: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register and access counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_nx;
            cnt_r   <= cnt_nx;
        end
    end

    // Request latch on grant; inputs are ignored until the next grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (gnt_rec) begin
            addr_r  <= rec_addr;
            wdata_r <= rec_wdata;
        end else if (gnt_ply) begin
            addr_r  <= ply_addr;
        end
    end

    // Read capture and completion pulses, issued on the TURN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_r     <= '0;
            rec_ack_r   <= 1'b0;
            ply_valid_r <= 1'b0;
        end else begin
            rec_ack_r   <= (state_r == WR) && last_cyc;
            ply_valid_r <= (state_r == RD) && last_cyc;
            if ((state_r == RD) && last_cyc) rdata_r <= sram_dq_i;
        end
    end

    assign sram_addr = addr_r;
    assign sram_dq_o = wdata_r;
    assign ply_rdata = rdata_r;
    assign rec_ack   = rec_ack_r;
    assign ply_valid = ply_valid_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter (ACCESS_CYC=2) with a small SRAM model,
// plus a randomised-request run on an ACCESS_CYC=1 instance.
module tb_sram_arbiter;

    logic        clk;
    logic        rst;

    logic        rec_req, ply_req, rec_ack, ply_valid, busy;
    logic [19:0] rec_addr, ply_addr, sram_addr;
    logic [15:0] rec_wdata, ply_rdata, sram_dq_o, sram_dq_i;
    logic        sram_dq_oe, sram_we_n, sram_ce_n, sram_oe_n, sram_ub_n, sram_lb_n;

    logic        r1_rec_req, r1_ply_req, r1_rec_ack, r1_ply_valid, r1_busy;
    logic [19:0] r1_rec_addr, r1_ply_addr, r1_sram_addr;
    logic [15:0] r1_rec_wdata, r1_ply_rdata, r1_sram_dq_o;
    logic        r1_dq_oe, r1_we_n, r1_ce_n, r1_oe_n, r1_ub_n, r1_lb_n;

    logic [15:0] mem [0:255];

    int total = 0;
    int bad   = 0;

    // {ce_n, oe_n, we_n, dq_oe, ub_n, lb_n}
    localparam logic [5:0] C_IDLE = 6'b111011;
    localparam logic [5:0] C_RD   = 6'b001000;
    localparam logic [5:0] C_WR   = 6'b010100;

    sram_arbiter #(.ACCESS_CYC(2)) u_dut (
        .clk(clk), .rst(rst),
        .rec_req(rec_req), .rec_addr(rec_addr), .rec_wdata(rec_wdata), .rec_ack(rec_ack),
        .ply_req(ply_req), .ply_addr(ply_addr), .ply_rdata(ply_rdata), .ply_valid(ply_valid),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
        .sram_we_n(sram_we_n), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n), .busy(busy)
    );

    sram_arbiter #(.ACCESS_CYC(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .rec_req(r1_rec_req), .rec_addr(r1_rec_addr), .rec_wdata(r1_rec_wdata), .rec_ack(r1_rec_ack),
        .ply_req(r1_ply_req), .ply_addr(r1_ply_addr), .ply_rdata(r1_ply_rdata), .ply_valid(r1_ply_valid),
        .sram_addr(r1_sram_addr), .sram_dq_o(r1_sram_dq_o), .sram_dq_oe(r1_dq_oe), .sram_dq_i(16'h0000),
        .sram_we_n(r1_we_n), .sram_ce_n(r1_ce_n), .sram_oe_n(r1_oe_n),
        .sram_ub_n(r1_ub_n), .sram_lb_n(r1_lb_n), .busy(r1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (!sram_ce_n && !sram_we_n) mem[sram_addr[7:0]] <= sram_dq_o;

    assign sram_dq_i = (!sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

    wire [5:0] ctrl = {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_ub_n, sram_lb_n};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int rec_wait, ply_wait;

    initial begin
        rst = 1'b1;
        rec_req = 0; ply_req = 0; rec_addr = '0; ply_addr = '0; rec_wdata = '0;
        r1_rec_req = 0; r1_ply_req = 0; r1_rec_addr = '0; r1_ply_addr = '0; r1_rec_wdata = '0;

        // Reset state
        tick();
        chk("rst ctrl", ctrl, C_IDLE);
        chk("rst busy", busy, 1'b0);
        chk("rst ack", rec_ack, 1'b0);
        chk("rst valid", ply_valid, 1'b0);
        chk("rst dq_o", sram_dq_o, 16'h0000);
        chk("rst rdata", ply_rdata, 16'h0000);
        rst = 1'b0;
        tick();
        chk("idle busy", busy, 1'b0);

        // Single write: 0xA5A5 -> 0x00010
        rec_req = 1; rec_addr = 20'h00010; rec_wdata = 16'hA5A5;
        tick();
        chk("wr1 ctrl", ctrl, C_WR);
        chk("wr1 busy", busy, 1'b1);
        chk("wr1 addr", sram_addr, 20'h00010);
        chk("wr1 dq_o", sram_dq_o, 16'hA5A5);
        rec_addr = 20'h0ABCD; rec_wdata = 16'hFFFF;
        tick();
        chk("wr2 ctrl", ctrl, C_WR);
        chk("wr2 dq_o", sram_dq_o, 16'hA5A5);
        chk("wr2 ack", rec_ack, 1'b0);
        tick();
        chk("wr turn ack", rec_ack, 1'b1);
        chk("wr turn ctrl", ctrl, C_IDLE);
        chk("wr turn addr", sram_addr, 20'h00010);
        chk("wr turn busy", busy, 1'b1);
        rec_req = 0;
        tick();
        chk("wr idle ack", rec_ack, 1'b0);
        chk("wr idle busy", busy, 1'b0);

        // Single read back from 0x00010
        ply_req = 1; ply_addr = 20'h00010;
        tick();
        chk("rd1 ctrl", ctrl, C_RD);
        chk("rd1 addr", sram_addr, 20'h00010);
        chk("rd1 valid", ply_valid, 1'b0);
        ply_addr = 20'h0FFFF;
        tick();
        chk("rd2 ctrl", ctrl, C_RD);
        chk("rd2 valid", ply_valid, 1'b0);
        chk("rd2 rdata", ply_rdata, 16'h0000);
        tick();
        chk("rd turn valid", ply_valid, 1'b1);
        chk("rd turn rdata", ply_rdata, 16'hA5A5);
        chk("rd turn ctrl", ctrl, C_IDLE);
        ply_req = 0;
        tick();
        chk("rd idle valid", ply_valid, 1'b0);
        chk("rd idle rdata", ply_rdata, 16'hA5A5);
        chk("rd idle busy", busy, 1'b0);

        // Simultaneous requests after reset: WR, RD, WR alternation
        rst = 1; tick(); rst = 0;
        chk("rst2 rdata", ply_rdata, 16'h0000);
        rec_req = 1; ply_req = 1; rec_addr = 20'h00020; rec_wdata = 16'h5A5A; ply_addr = 20'h00020;
        tick(); chk("alt wr ctrl", ctrl, C_WR);
        tick(); chk("alt wr2 ctrl", ctrl, C_WR);
        tick(); chk("alt wr ack", rec_ack, 1'b1); chk("alt wr nvalid", ply_valid, 1'b0);
        tick(); chk("alt idle busy", busy, 1'b0);
        tick(); chk("alt rd ctrl", ctrl, C_RD);
        tick(); chk("alt rd2 ctrl", ctrl, C_RD);
        tick(); chk("alt rd valid", ply_valid, 1'b1); chk("alt rd rdata", ply_rdata, 16'h5A5A);
        chk("alt rd nack", rec_ack, 1'b0);
        tick(); chk("alt idle2 busy", busy, 1'b0);
        tick(); chk("alt wr3 ctrl", ctrl, C_WR);
        rec_req = 0; ply_req = 0;
        tick(); chk("alt wr3b ctrl", ctrl, C_WR);
        tick(); chk("alt wr3 ack", rec_ack, 1'b1);
        tick(); chk("alt end busy", busy, 1'b0);

        // Read request dropped after first RD cycle still completes
        ply_req = 1; ply_addr = 20'h00010;
        tick(); chk("drop rd1 ctrl", ctrl, C_RD);
        ply_req = 0;
        tick(); chk("drop rd2 ctrl", ctrl, C_RD);
        tick(); chk("drop valid", ply_valid, 1'b1); chk("drop rdata", ply_rdata, 16'hA5A5);
        tick(); chk("drop idle busy", busy, 1'b0); chk("drop valid off", ply_valid, 1'b0);
        tick(); chk("drop stay idle", busy, 1'b0);

        // Reset during the second WR cycle aborts the write
        rec_req = 1; rec_addr = 20'h00030; rec_wdata = 16'h1234;
        tick(); chk("abort wr1 ctrl", ctrl, C_WR);
        tick(); chk("abort wr2 ctrl", ctrl, C_WR);
        rst = 1;
        #1;
        chk("abort ctrl", ctrl, C_IDLE);
        chk("abort busy", busy, 1'b0);
        chk("abort ack", rec_ack, 1'b0);
        chk("abort dq_o", sram_dq_o, 16'h0000);
        chk("abort addr", sram_addr, 20'h00000);
        tick();
        chk("abort ack edge", rec_ack, 1'b0);
        ply_req = 1; ply_addr = 20'h00010;
        rst = 0;
        tick(); chk("restart rec wins", ctrl, C_WR); chk("restart addr", sram_addr, 20'h00030);
        ply_req = 0;
        tick(); chk("restart wr2", ctrl, C_WR);
        tick(); chk("restart ack", rec_ack, 1'b1);
        rec_req = 0;
        tick(); chk("restart idle", busy, 1'b0);

        // ACCESS_CYC=1 instance under random requests
        rec_wait = 0; ply_wait = 0;
        for (int i = 0; i < 3000; i++) begin
            if (r1_rec_req && r1_rec_ack) r1_rec_req = 0;
            else if (!r1_rec_req && ($urandom_range(0, 1) == 1)) begin
                r1_rec_req = 1; r1_rec_addr = 20'($urandom); r1_rec_wdata = 16'($urandom); rec_wait = 0;
            end
            if (r1_ply_req && r1_ply_valid) r1_ply_req = 0;
            else if (!r1_ply_req && ($urandom_range(0, 1) == 1)) begin
                r1_ply_req = 1; r1_ply_addr = 20'($urandom); ply_wait = 0;
            end
            tick();
            if (r1_rec_req) rec_wait++;
            if (r1_ply_req) ply_wait++;
            chk("r1 we_oe overlap", r1_we_n | r1_oe_n, 1'b1);
            if (r1_busy && r1_we_n) chk("r1 dq_oe rd/turn", r1_dq_oe, 1'b0);
            if (r1_rec_ack) chk("r1 rec latency", (rec_wait <= 6), 1'b1);
            if (r1_ply_valid) chk("r1 ply latency", (ply_wait <= 6), 1'b1);
            if (r1_rec_req && rec_wait > 6) chk("r1 rec starved", rec_wait, 6);
            if (r1_ply_req && ply_wait > 6) chk("r1 ply starved", ply_wait, 6);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
